fmul_seq: RTL



---
 rtl/fp_pkg.sv | 34 +++
 rtl/fmul_seq_if.sv | 27 ++
 rtl/fp_classify.sv | 14 +
 rtl/fmul_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision multiply sequencer:
// FSM state encoding, IEEE-754 field ranges, flag bit positions and exponent-sum limits.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_CAPT,
        ST_DONE
    } state_t;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int MAN_HI   = 22;
    localparam int MAN_LO   = 0;

    // out_flags = {nv, of, uf, byp}
    localparam int FLG_NV  = 3;
    localparam int FLG_OF  = 2;
    localparam int FLG_UF  = 1;
    localparam int FLG_BYP = 0;

    // Limits on the biased exponent sum ea + eb (result biased exponent is s - BIAS).
    localparam logic [8:0] SUM_OF_MIN  = 9'(2 * BIAS + 128);
    localparam logic [8:0] SUM_OF_EDGE = 9'(2 * BIAS + 127);
    localparam logic [8:0] SUM_UF_EDGE = 9'(BIAS);

endpackage

// File: rtl/fmul_seq_if.sv
// Operand/result handshakes plus the multiplier-core strobe/data lines, bundled for fmul_seq.
// master = environment driving operands and the core result; slave = the sequencer.
interface fmul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mul_en;
    logic        mul_load;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, in_a, in_b, mul_result, out_ready,
        input  in_ready, mul_en, mul_load, mul_a, mul_b, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, mul_result, out_ready,
        output in_ready, mul_en, mul_load, mul_a, mul_b, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_classify.sv
// Combinational zero/inf/NaN classifier for one single-precision operand; denormals count as zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [7:0]  exp,
    input  logic [22:0] man,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);
    assign is_zero = (exp == 8'h00);
    assign is_inf  = (exp == EXP_MAX) && (man == 23'h0);
    assign is_nan  = (exp == EXP_MAX) && (man != 23'h0);
endmodule

// File: rtl/fmul_seq.sv
// Sequencer/exception wrapper ahead of the FP multiplier core: bypasses specials, flushes of/uf.
// Latency 4 via core, 1 on bypass; one op in flight, result held in DONE while out_ready is low.
module fmul_seq
    import fp_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    fmul_seq_if.slave bus
);
    state_t      state, state_nxt;
    logic [31:0] a_q, b_q, res_q;
    logic [3:0]  flg_q;
    logic        sign_q;
    logic [8:0]  sum_q;

    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic sign_in, invalid, any_inf, any_zero, special;
    logic [8:0]  sum_in;
    logic [31:0] byp_res, capt_res;
    logic [3:0]  byp_flg, capt_flg;
    logic [7:0]  core_exp;

    fp_classify u_cls_a (
        .exp     (bus.in_a[EXP_HI:EXP_LO]),
        .man     (bus.in_a[MAN_HI:MAN_LO]),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan)
    );

    fp_classify u_cls_b (
        .exp     (bus.in_b[EXP_HI:EXP_LO]),
        .man     (bus.in_b[MAN_HI:MAN_LO]),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan)
    );

    assign sign_in  = bus.in_a[SIGN_BIT] ^ bus.in_b[SIGN_BIT];
    assign sum_in   = {1'b0, bus.in_a[EXP_HI:EXP_LO]} + {1'b0, bus.in_b[EXP_HI:EXP_LO]};
    assign invalid  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign any_inf  = a_inf | b_inf;
    assign any_zero = a_zero | b_zero;
    assign special  = invalid | any_inf | any_zero;

    always_comb begin
        byp_res = 32'h0;
        byp_flg = 4'h0;
        byp_flg[FLG_BYP] = 1'b1;
        if (invalid) begin
            byp_res = QNAN;
            byp_flg[FLG_NV] = 1'b1;
        end else if (any_inf) begin
            byp_res = {sign_in, EXP_MAX, 23'h0};
        end else begin
            byp_res = {sign_in, 31'h0};
        end
    end

    // The core only sees the true exponent near the edges, so the latched sum decides the clear cases.
    assign core_exp = bus.mul_result[EXP_HI:EXP_LO];

    always_comb begin
        capt_res = bus.mul_result;
        capt_flg = 4'h0;
        if (sum_q >= SUM_OF_MIN || (sum_q == SUM_OF_EDGE && core_exp == EXP_MAX)) begin
            capt_res = {sign_q, EXP_MAX, 23'h0};
            capt_flg[FLG_OF] = 1'b1;
        end else if (sum_q < SUM_UF_EDGE || (sum_q == SUM_UF_EDGE && core_exp == 8'h00)) begin
            capt_res = {sign_q, 31'h0};
            capt_flg[FLG_UF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = special ? ST_DONE : ST_LOAD;
            ST_LOAD: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.mul_en    = 1'b0;
        bus.mul_load  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ST_IDLE: bus.in_ready = 1'b1;
            ST_LOAD: begin
                bus.mul_en   = 1'b1;
                bus.mul_load = 1'b1;
            end
            ST_EXEC: bus.mul_en = 1'b1;
            ST_DONE: bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= 32'h0;
            b_q    <= 32'h0;
            res_q  <= 32'h0;
            flg_q  <= 4'h0;
            sign_q <= 1'b0;
            sum_q  <= 9'h0;
        end else begin
            if (state == ST_IDLE && bus.in_valid) begin
                a_q    <= bus.in_a;
                b_q    <= bus.in_b;
                sign_q <= sign_in;
                sum_q  <= sum_in;
                if (special) begin
                    res_q <= byp_res;
                    flg_q <= byp_flg;
                end
            end
            if (state == ST_CAPT) begin
                res_q <= capt_res;
                flg_q <= capt_flg;
            end
        end
    end

    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.out_result = res_q;
    assign bus.out_flags  = flg_q;
endmodule
